rom_loader: RTL and testbench
=============================

# rom_loader

Initiator for the puzzle ROM read port. On `start` it reads all 81 cells in address order, one per cycle, validates each byte, and unpacks the puzzle into a parallel 9x9 grid with a givens mask, empty-cell count, and error flags. It sits between the ROM and the solver core. The solver starts once `done` pulses.

## Interface
- `WIDTH`, 8, ROM data width; values 0–9 are legal.
- `CELLS`, 81, number of ROM words and grid cells; `AW = $clog2(CELLS)` is a localparam.
- `clk`  in  1  clock; all flops are rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  load request; sampled only in IDLE.
- `busy`  out  1  high while in FETCH.
- `done`  out  1  one-cycle pulse after the last cell is captured.
- `ROM_rd`  out  1  ROM read enable.
- `ROM_addr`  out  AW  ROM address; equals the index of the cell being fetched.
- `ROM_data`  in  WIDTH  ROM output; the ROM updates it on the falling clock edge while `ROM_rd` is high.
- `grid`  out  CELLS*4  cell k occupies bits [4k+3:4k], row-major (k = row*9+col); 0 means empty.
- `given`  out  CELLS  bit k is set when cell k is nonzero.
- `empty_cnt`  out  7  number of zero cells, range 0..81.
- `err`  out  1  sticky: some byte was greater than 9.
- `conflict`  out  1  sticky: a nonzero value repeats within a row, column or 3x3 box.

## Operation
- Reset value of every output and register is 0. The FSM resets to IDLE.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - `ROM_rd` = 0.
  - On `start`: clear `grid`, `given`, `empty_cnt`, `err`, `conflict`, all seen-masks, and the row/col/box counters.
  - Set `ROM_addr` = 0 and go to FETCH.
- FETCH:
  - `ROM_rd` = 1 and `busy` = 1.
  - On each clock edge, capture `ROM_data` as cell `ROM_addr`, then increment `ROM_addr`, row, col and box.
  - When `ROM_addr` == CELLS-1, capture that cell and go to DONE. `ROM_addr` holds at CELLS-1.
- DONE:
  - `done` = 1 and `ROM_rd` = 0 for exactly one cycle, then go to IDLE.
- Capture rules for value v:
  - v > 9: store 0, leave the `given` bit clear, increment `empty_cnt`, set `err`.
  - v == 0: store 0 and increment `empty_cnt`.
  - 1..9: store v[3:0] and set the `given` bit. If bit v-1 is already set in the seen-mask of this cell's row, column or box, set `conflict`. Then set bit v-1 in all three masks.
- Index tracking:
  - col wraps 8→0, and row increments on that wrap.
  - box = (row/3)*3 + col/3, maintained by counters; no dividers.
- `start` while in FETCH or DONE is ignored and not queued.
- `ROM_rd` is low outside FETCH, so `ROM_data` holds its last value.
- Outputs hold their values after `done` until the next accepted `start`.
- Reset asserted mid-load: the load aborts immediately, all outputs go to 0, and the FSM is in IDLE. A new `start` is required.

## Timing
- Read latency:
  - `ROM_addr` and `ROM_rd` change after rising edge Pk.
  - The ROM updates on the following falling edge.
  - The loader captures at rising edge Pk+1.
  - Throughput is one cell per cycle with no bubbles.
- With `start` sampled at edge E0:
  - FETCH lasts 81 cycles, and cell k is captured at edge E(k+1).
  - `done` is high in the cycle following E81.
  - IDLE is re-entered at E82, and the next `start` can be accepted at E82.
- `grid`, `given`, `empty_cnt`, `err` and `conflict` are final and stable when `done` is high.
- `busy` and `done` are never high in the same cycle.

## Structure
- `sudoku_pkg` holds:
  - `CELLS` = 81 and `N` = 9.
  - `cell_t` (logic [3:0]).
  - state enum `ld_state_e` {IDLE, FETCH, DONE}.
  - typedef `mask_t` (logic [8:0]).
- Sub-module `cell_idx_cnt` produces row, col and box (4 bits each) with clear and advance inputs. It is shared with the solver's cell scanner.
- `rom_loader` contains the FSM, capture/validate logic, 27 seen-masks, and the output registers.

## Test plan
- data1 with 40 givens:
  - `ROM_rd` is high for exactly 81 cycles and `ROM_addr` runs 0..80.
  - `done` pulses at E81+1, `grid` matches the file, and `empty_cnt` = 41.
  - `err` = 0 and `conflict` = 0.
- Byte 8'd12 at address 5: cell 5 = 0, `given`[5] = 0, `err` = 1, `empty_cnt` counts it.
- Value 7 at addresses 0 and 8 (same row): `conflict` = 1. Repeat with addresses 0 and 72 (same column) and addresses 0 and 20 (same box).
- `start` pulsed again at cycles 10 and 81 of FETCH: no restart, `done` pulses once, data is unchanged.
- `rst` low at FETCH cycle 40:
  - All outputs are 0 and `ROM_rd` is 0 immediately.
  - After release plus `start`, a full correct load completes.
- Back-to-back loads with `start` held high: the second load begins at E82, clears the prior outputs, and its `done` arrives 82 cycles after the first.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared types for the puzzle loader and solver: cell/mask types, grid size, loader states.
package sudoku_pkg;

   localparam int CELLS = 81;
   localparam int N     = 9;

   typedef logic [3:0] cell_t;
   typedef logic [8:0] mask_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DONE
   } ld_state_e;

   // One-hot digit bit for values 1..9; only meaningful for nonzero v.
   function automatic mask_t value_bit(input cell_t v);
      return mask_t'(1) << (v - cell_t'(1));
   endfunction

endpackage

// File: rtl/cell_idx_cnt.sv
// Row-major cell index walker: row, col and 3x3 box tracked by counters, no dividers.
module cell_idx_cnt
   import sudoku_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       adv,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] box
);

   logic [3:0] row_q, row_d, col_q, col_d, box_q, box_d, base_q, base_d;
   logic [1:0] csub_q, csub_d, rsub_q, rsub_d;

   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      box_d  = box_q;
      base_d = base_q;
      csub_d = csub_q;
      rsub_d = rsub_q;
      if (clr) begin
         row_d  = '0;
         col_d  = '0;
         box_d  = '0;
         base_d = '0;
         csub_d = '0;
         rsub_d = '0;
      end else if (adv) begin
         if (col_q == 4'(N - 1)) begin
            col_d  = '0;
            csub_d = '0;
            row_d  = row_q + 4'd1;
            // base_d is the first box of the current band of three rows
            if (rsub_q == 2'd2) begin
               rsub_d = '0;
               base_d = base_q + 4'd3;
            end else begin
               rsub_d = rsub_q + 2'd1;
            end
            box_d = base_d;
         end else begin
            col_d = col_q + 4'd1;
            if (csub_q == 2'd2) begin
               csub_d = '0;
               box_d  = box_q + 4'd1;
            end else begin
               csub_d = csub_q + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q  <= '0;
         col_q  <= '0;
         box_q  <= '0;
         base_q <= '0;
         csub_q <= '0;
         rsub_q <= '0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         box_q  <= box_d;
         base_q <= base_d;
         csub_q <= csub_d;
         rsub_q <= rsub_d;
      end
   end

   assign row = row_q;
   assign col = col_q;
   assign box = box_q;

endmodule

// File: rtl/rom_loader.sv
// Streams the 81 puzzle bytes from ROM, validates each one and unpacks the grid,
// givens mask, empty count and error/conflict flags for the solver core.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last load
// FETCH | one ROM read and one cell capture per cycle
// DONE  | one-cycle done pulse; results are final
module rom_loader #(
   parameter int  WIDTH = 8,
   parameter int  CELLS = 81,
   localparam int AW    = $clog2(CELLS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               ROM_rd,
   output logic [AW-1:0]      ROM_addr,
   input  logic [WIDTH-1:0]   ROM_data,
   output logic [CELLS*4-1:0] grid,
   output logic [CELLS-1:0]   given,
   output logic [6:0]         empty_cnt,
   output logic               err,
   output logic               conflict
);
   import sudoku_pkg::*;

   ld_state_e          state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [CELLS*4-1:0] grid_q, grid_d;
   logic [CELLS-1:0]   given_q, given_d;
   logic [6:0]         empty_q, empty_d;
   logic               err_q, err_d, conflict_q, conflict_d;
   mask_t              row_mask_q [N], row_mask_d [N];
   mask_t              col_mask_q [N], col_mask_d [N];
   mask_t              box_mask_q [N], box_mask_d [N];

   logic [3:0] row, col, box;
   logic       accept, idx_adv;
   logic       v_bad;
   cell_t      v;
   mask_t      v_bit;

   cell_idx_cnt u_idx (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .adv (idx_adv),
      .row (row),
      .col (col),
      .box (box)
   );

   assign v_bad = ROM_data > WIDTH'(9);
   assign v     = ROM_data[3:0];
   assign v_bit = value_bit(v);

   // A start on the edge leaving DONE is the IDLE-entry start, so loads run back to back.
   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      grid_d     = grid_q;
      given_d    = given_q;
      empty_d    = empty_q;
      err_d      = err_q;
      conflict_d = conflict_q;
      row_mask_d = row_mask_q;
      col_mask_d = col_mask_q;
      box_mask_d = box_mask_q;
      idx_adv    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) state_d = FETCH;
         end
         FETCH: begin
            idx_adv = 1'b1;
            if (v_bad) begin
               empty_d = empty_q + 7'd1;
               err_d   = 1'b1;
            end else if (v == '0) begin
               empty_d = empty_q + 7'd1;
            end else begin
               grid_d[4*addr_q +: 4] = v;
               given_d[addr_q]       = 1'b1;
               if (|(v_bit & (row_mask_q[row] | col_mask_q[col] | box_mask_q[box])))
                  conflict_d = 1'b1;
               row_mask_d[row] = row_mask_q[row] | v_bit;
               col_mask_d[col] = col_mask_q[col] | v_bit;
               box_mask_d[box] = box_mask_q[box] | v_bit;
            end
            if (addr_q == AW'(CELLS - 1)) state_d = DONE;
            else                          addr_d  = addr_q + AW'(1);
         end
         DONE: begin
            state_d = start ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         addr_d     = '0;
         grid_d     = '0;
         given_d    = '0;
         empty_d    = '0;
         err_d      = 1'b0;
         conflict_d = 1'b0;
         row_mask_d = '{default: '0};
         col_mask_d = '{default: '0};
         box_mask_d = '{default: '0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         grid_q     <= '0;
         given_q    <= '0;
         empty_q    <= '0;
         err_q      <= 1'b0;
         conflict_q <= 1'b0;
         row_mask_q <= '{default: '0};
         col_mask_q <= '{default: '0};
         box_mask_q <= '{default: '0};
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         grid_q     <= grid_d;
         given_q    <= given_d;
         empty_q    <= empty_d;
         err_q      <= err_d;
         conflict_q <= conflict_d;
         row_mask_q <= row_mask_d;
         col_mask_q <= col_mask_d;
         box_mask_q <= box_mask_d;
      end
   end

   assign busy      = (state_q == FETCH);
   assign done      = (state_q == DONE);
   assign ROM_rd    = (state_q == FETCH);
   assign ROM_addr  = addr_q;
   assign grid      = grid_q;
   assign given     = given_q;
   assign empty_cnt = empty_q;
   assign err       = err_q;
   assign conflict  = conflict_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: behavioural ROM, reference unpack model, timing checks.
module tb_rom_loader;

   localparam int NC = 81;

   logic            clk   = 1'b0;
   logic            rst   = 1'b0;
   logic            start = 1'b0;
   logic            busy, done, ROM_rd;
   logic [6:0]      ROM_addr;
   logic [7:0]      ROM_data = '0;
   logic [NC*4-1:0] grid;
   logic [NC-1:0]   given;
   logic [6:0]      empty_cnt;
   logic            err, conflict;

   logic [7:0]      rom [NC];
   int              total = 0;
   int              bad   = 0;

   logic [NC*4-1:0] exp_grid;
   logic [NC-1:0]   exp_given;
   int              exp_empty;
   logic            exp_err, exp_conf;
   int              rd_cnt, done_at, done_cnt, addr_bad, overlap;

   rom_loader #(.WIDTH(8), .CELLS(NC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .ROM_rd    (ROM_rd),
      .ROM_addr  (ROM_addr),
      .ROM_data  (ROM_data),
      .grid      (grid),
      .given     (given),
      .empty_cnt (empty_cnt),
      .err       (err),
      .conflict  (conflict)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ROM_rd) ROM_data = rom[ROM_addr];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_zero();
      for (int k = 0; k < NC; k++) rom[k] = 8'd0;
   endtask

   // Valid solution pattern; even cells below 80 are givens -> 40 givens, 41 empty.
   task automatic fill_data1();
      for (int k = 0; k < NC; k++) begin
         int r, c;
         r = k / 9;
         c = k % 9;
         if ((k % 2 == 0) && (k != 80)) rom[k] = 8'(((r * 3 + r / 3 + c) % 9) + 1);
         else                            rom[k] = 8'd0;
      end
   endtask

   task automatic build_model();
      exp_grid  = '0;
      exp_given = '0;
      exp_empty = 0;
      exp_err   = 1'b0;
      exp_conf  = 1'b0;
      for (int k = 0; k < NC; k++) begin
         if (rom[k] > 8'd9) begin
            exp_err = 1'b1;
            exp_empty++;
         end else if (rom[k] == 8'd0) begin
            exp_empty++;
         end else begin
            exp_grid[4*k +: 4] = rom[k][3:0];
            exp_given[k]       = 1'b1;
         end
      end
      for (int a = 0; a < NC; a++)
         for (int b = a + 1; b < NC; b++)
            if (exp_given[a] && exp_given[b] && rom[a] == rom[b] &&
                ((a / 9 == b / 9) || (a % 9 == b % 9) ||
                 ((a / 27 == b / 27) && ((a % 9) / 3 == (b % 9) / 3))))
               exp_conf = 1'b1;
   endtask

   task automatic check_outputs(input string pfx);
      build_model();
      chk({pfx, "_grid"},     grid,      exp_grid);
      chk({pfx, "_given"},    given,     exp_given);
      chk({pfx, "_empty"},    empty_cnt, exp_empty);
      chk({pfx, "_err"},      err,       exp_err);
      chk({pfx, "_conflict"}, conflict,  exp_conf);
   endtask

   // Starts a load from IDLE and watches 100 cycles; n counts edges after the start edge E0.
   task automatic run_load(input bit inj_start, input bit inj_rst);
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      rd_cnt   = 0;
      done_at  = -1;
      done_cnt = 0;
      addr_bad = 0;
      overlap  = 0;
      for (int n = 0; n < 100; n++) begin
         if (busy && done) overlap++;
         if (ROM_rd) begin
            if (int'(ROM_addr) != rd_cnt) addr_bad++;
            rd_cnt++;
         end
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
         end
         if (inj_rst && n == 39) begin
            rst = 1'b0;
            #1;
            chk("midrst_outs", {busy, done, ROM_rd, ROM_addr, grid, given, empty_cnt, err, conflict}, '0);
            @(posedge clk); #1;
            rst = 1'b1;
            break;
         end
         start = inj_start && (n == 9 || n == 80);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   initial begin
      int pair_addr [4] = '{8, 72, 20, 40};
      int pair_conf [4] = '{1, 1, 1, 0};
      int first_done, second_done, b2b_dones;

      fill_data1();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {busy, done, ROM_rd, ROM_addr, grid, given, empty_cnt, err, conflict}, '0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_load(1'b0, 1'b0);
      chk("d1_rd_cycles", rd_cnt, 81);
      chk("d1_addr_seq",  addr_bad, 0);
      chk("d1_done_at",   done_at, 81);
      chk("d1_done_cnt",  done_cnt, 1);
      chk("d1_overlap",   overlap, 0);
      check_outputs("d1");
      chk("d1_empty41",   empty_cnt, 41);
      chk("d1_err0",      err, 0);
      chk("d1_conf0",     conflict, 0);
      chk("d1_cell0",     grid[3:0], 1);
      chk("d1_cell10",    grid[43:40], 5);

      fill_zero();
      rom[5] = 8'd12;
      rom[6] = 8'd3;
      run_load(1'b0, 1'b0);
      check_outputs("bad");
      chk("bad_err1",   err, 1);
      chk("bad_cell5",  grid[23:20], 0);
      chk("bad_given5", given[5], 0);
      chk("bad_cell6",  grid[27:24], 3);
      chk("bad_empty",  empty_cnt, 80);

      for (int i = 0; i < 4; i++) begin
         fill_zero();
         rom[0]            = 8'd7;
         rom[pair_addr[i]] = 8'd7;
         run_load(1'b0, 1'b0);
         chk($sformatf("conf_%0d", pair_addr[i]), conflict, pair_conf[i]);
         chk($sformatf("conf_%0d_empty", pair_addr[i]), empty_cnt, 79);
      end

      fill_data1();
      run_load(1'b1, 1'b0);
      chk("rs_rd_cycles", rd_cnt, 81);
      chk("rs_done_at",   done_at, 81);
      chk("rs_done_cnt",  done_cnt, 1);
      check_outputs("rs");

      run_load(1'b0, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("midrst_idle", {ROM_rd, busy, done}, 3'b000);
      run_load(1'b0, 1'b0);
      chk("post_rd_cycles", rd_cnt, 81);
      chk("post_done_at",   done_at, 81);
      check_outputs("post");

      first_done  = -1;
      second_done = -1;
      b2b_dones   = 0;
      start = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n < 200; n++) begin
         if (done) begin
            b2b_dones++;
            if (first_done < 0)       first_done  = n;
            else if (second_done < 0) second_done = n;
         end
         if (n == 82) begin
            chk("b2b_cleared", {given, empty_cnt}, '0);
            chk("b2b_restart_rd", ROM_rd, 1);
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      chk("b2b_first",   first_done, 81);
      chk("b2b_spacing", second_done - first_done, 82);
      chk("b2b_dones",   b2b_dones, 2);
      check_outputs("b2b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
